// File: rtl/dffre_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dffre_pipe
// Description : Elastic register pipeline with a valid/ready handshake.
//               Carries a WIDTH-bit payload through DEPTH stages with global
//               enable, synchronous flush, bubble collapsing and an
//               occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module dffre_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         r,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int c_OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_vld;
    logic [WIDTH-1:0] r_dat [DEPTH];

    logic [DEPTH-1:0] w_load;
    logic             w_upd;
    logic             w_accept;
    logic [c_OCC_W-1:0] w_occ;

    // The backward advance chain adv[i] = vld[i] & (~vld[i+1] | adv[i+1])
    // flattens to: stage i may load when the output is draining or any
    // stage at or above i is empty. Computing it this way keeps each bit a
    // direct function of state and out_ready, with no ripple through
    // neighbouring load bits.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_load
            assign w_load[i] = out_ready | ~(&r_vld[DEPTH-1:i]);
        end
    endgenerate

    assign w_upd     = en & ~flush;
    assign in_ready  = w_upd & w_load[0];
    assign w_accept  = in_valid & in_ready;
    assign out_valid = en & r_vld[DEPTH-1];
    assign out_data  = r_dat[DEPTH-1];

    // Stage registers: reset, flush of valid bits, or per-stage shift/hold.
    always_ff @(posedge clk) begin
        if (r) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dat[i] <= RESET_VAL;
            end
        end else if (en) begin
            if (flush) begin
                // Payload is left in place; only the valid bits are cleared.
                r_vld <= '0;
            end else begin
                if (w_load[0]) begin
                    r_vld[0] <= w_accept;
                    if (w_accept) begin
                        r_dat[0] <= in_data;
                    end
                end
                for (int i = 1; i < DEPTH; i++) begin
                    if (w_load[i]) begin
                        r_vld[i] <= r_vld[i-1];
                        if (r_vld[i-1]) begin
                            r_dat[i] <= r_dat[i-1];
                        end
                    end
                end
            end
        end
    end

    // Occupancy is the population count of the registered valid bits.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + c_OCC_W'(r_vld[i]);
        end
    end

    assign occupancy = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_dffre_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_dffre_pipe
// Description : Self-checking bench for dffre_pipe (WIDTH=8, DEPTH=3,
//               RESET_VAL=8'hA5): directed vector table, directed
//               multi-cycle sequences and random stimulus against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dffre_pipe;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] RVAL  = 8'hA5;

    logic       clk;
    logic       r;
    logic       en;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] occupancy;

    int checks = 0;
    int errors = 0;

    dffre_pipe #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .RESET_VAL(RVAL)
    ) dut (
        .clk      (clk),
        .r        (r),
        .en       (en),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       r, en, flush, iv;
        logic [7:0] d;
        logic       o;
        logic       eir, eov;
        logic [7:0] edat;
        logic [1:0] eocc;
    } vec_t;

    function automatic vec_t mk(input logic rr, e, f, iv, input logic [7:0] d, input logic o,
                                input logic eir, eov, input logic [7:0] edat, input logic [1:0] eocc);
        vec_t v;
        v.r = rr; v.en = e; v.flush = f; v.iv = iv; v.d = d; v.o = o;
        v.eir = eir; v.eov = eov; v.edat = edat; v.eocc = eocc;
        return v;
    endfunction

    vec_t tbl [14];

    // ---------------- reference model ----------------
    // Items held oldest-first with their stage position. Each cycle every
    // item moves one stage forward unless blocked by the item ahead of it.
    int         m_pos [$];
    logic [7:0] m_dat [$];
    logic [7:0] m_last;

    task automatic step(input logic rr, input logic e, input logic f, input logic iv,
                        input logic [7:0] d, input logic o, input bit chk);
        int         np [$];
        int         lim;
        bit         ov_m, xfer, ir_m;
        int         keep_pos [$];
        logic [7:0] keep_dat [$];
        r = rr; en = e; flush = f; in_valid = iv; in_data = d; out_ready = o;
        #3;
        ov_m = e && (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1);
        xfer = ov_m && o;
        lim  = DEPTH;
        foreach (m_pos[k]) begin
            int n;
            if (k == 0 && xfer) begin
                np.push_back(DEPTH);
            end else begin
                n = m_pos[k] + 1;
                if (n > lim - 1) n = lim - 1;
                np.push_back(n);
                lim = n;
            end
        end
        ir_m = e && !f && (lim > 0);
        if (chk) begin
            check("in_ready",  32'(in_ready),  32'(ir_m));
            check("out_valid", 32'(out_valid), 32'(ov_m));
            check("out_data",  32'(out_data),  32'(m_last));
            check("occupancy", 32'(occupancy), 32'(m_pos.size()));
        end
        @(posedge clk);
        #1;
        if (rr) begin
            m_pos.delete(); m_dat.delete(); m_last = RVAL;
        end else if (e && f) begin
            m_pos.delete(); m_dat.delete();
        end else if (e) begin
            foreach (m_pos[k]) begin
                if (np[k] < DEPTH) begin
                    keep_pos.push_back(np[k]);
                    keep_dat.push_back(m_dat[k]);
                end
            end
            if (iv && ir_m) begin
                keep_pos.push_back(0);
                keep_dat.push_back(d);
            end
            m_pos = keep_pos;
            m_dat = keep_dat;
            if (m_pos.size() > 0 && m_pos[0] == DEPTH - 1) m_last = m_dat[0];
        end
    endtask

    initial begin
        r = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        m_last = RVAL;

        //           r  en fl iv  data   o   ir ov  data   occ
        tbl[0]  = mk(1, 1, 0, 0, 8'h00, 1,  1, 0, 8'hA5, 2'd0);
        tbl[1]  = mk(0, 1, 0, 1, 8'h01, 1,  1, 0, 8'hA5, 2'd0);
        tbl[2]  = mk(0, 1, 0, 1, 8'h02, 1,  1, 0, 8'hA5, 2'd1);
        tbl[3]  = mk(0, 1, 0, 1, 8'h03, 1,  1, 0, 8'hA5, 2'd2);
        tbl[4]  = mk(0, 1, 0, 0, 8'h00, 1,  1, 1, 8'h01, 2'd3);
        tbl[5]  = mk(0, 1, 0, 0, 8'h00, 0,  1, 1, 8'h02, 2'd2);
        tbl[6]  = mk(0, 0, 0, 1, 8'h09, 1,  0, 0, 8'h02, 2'd2);
        tbl[7]  = mk(0, 1, 1, 1, 8'h0A, 1,  0, 1, 8'h02, 2'd2);
        tbl[8]  = mk(0, 1, 0, 0, 8'h00, 1,  1, 0, 8'h02, 2'd0);
        tbl[9]  = mk(1, 0, 0, 0, 8'h00, 1,  0, 0, 8'h02, 2'd0);
        tbl[10] = mk(0, 1, 0, 1, 8'h55, 0,  1, 0, 8'hA5, 2'd0);
        tbl[11] = mk(0, 1, 0, 0, 8'h00, 0,  1, 0, 8'hA5, 2'd1);
        tbl[12] = mk(0, 1, 0, 0, 8'h00, 0,  1, 0, 8'hA5, 2'd1);
        tbl[13] = mk(0, 1, 0, 0, 8'h00, 0,  1, 1, 8'h55, 2'd1);

        // First reset edge brings the state out of X; nothing is compared.
        @(posedge clk);
        #1;

        for (int k = 0; k < 14; k++) begin
            r = tbl[k].r; en = tbl[k].en; flush = tbl[k].flush;
            in_valid = tbl[k].iv; in_data = tbl[k].d; out_ready = tbl[k].o;
            #3;
            check("tbl_in_ready",  32'(in_ready),  32'(tbl[k].eir));
            check("tbl_out_valid", 32'(out_valid), 32'(tbl[k].eov));
            check("tbl_out_data",  32'(out_data),  32'(tbl[k].edat));
            check("tbl_occupancy", 32'(occupancy), 32'(tbl[k].eocc));
            @(posedge clk);
            #1;
        end

        // Synchronise the model with a reset (DUT state unknown to model).
        step(1, 1, 0, 0, 8'h00, 1, 0);
        step(1, 1, 0, 0, 8'h00, 1, 1);

        // Streaming with out_ready held high.
        for (int v = 1; v <= 10; v++) step(0, 1, 0, 1, 8'(v), 1, 1);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 8'h00, 1, 1);

        // Backpressure, then release.
        for (int v = 1; v <= 4; v++) step(0, 1, 0, 1, 8'(v), 0, 1);
        step(0, 1, 0, 1, 8'h05, 0, 1);
        for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 8'h00, 1, 1);

        // Full pipe with simultaneous accept and transfer.
        for (int v = 0; v < 3; v++) step(0, 1, 0, 1, 8'h20 + 8'(v), 0, 1);
        for (int v = 0; v < 5; v++) step(0, 1, 0, 1, 8'h30 + 8'(v), 1, 1);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 8'h00, 1, 1);

        // Enable freeze mid-stream.
        for (int v = 0; v < 3; v++) step(0, 1, 0, 1, 8'h40 + 8'(v), 1, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 8'hEE, 1, 1);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 8'h00, 1, 1);

        // Flush with two items, the older one presented at the output.
        step(0, 1, 0, 1, 8'h61, 0, 1);
        step(0, 1, 0, 1, 8'h62, 0, 1);
        step(0, 1, 0, 0, 8'h00, 0, 1);
        step(0, 1, 1, 1, 8'h63, 1, 1);
        step(0, 1, 0, 0, 8'h00, 1, 1);
        step(0, 1, 0, 0, 8'h00, 1, 1);

        // Reset while disabled.
        step(0, 1, 0, 1, 8'h71, 0, 1);
        step(0, 1, 0, 1, 8'h72, 0, 1);
        step(1, 0, 0, 1, 8'h73, 1, 1);
        step(0, 1, 0, 0, 8'h00, 1, 1);

        // Random stimulus.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom),
                 ($urandom_range(0, 2) != 0),
                 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
